alien_bomb_ctrl: RTL and testbench
==================================

// Module: alien_bomb_ctrl
// PURPOSE
//  Downward projectile engine: alien bombs fall toward the player cannon.
//  Sits beside the alien formation. The formation raises fire requests at
//  a launch point. This block owns NUM_BOMBS bomb slots and moves them once
//  per frame. It detects cannon hits and drives the bomb pixel into the mixer.
// PARAMETERS
//  NUM_BOMBS     3    bomb slots (1..8)
//  SCALING       4    pixel scale factor
//  BOMB_SPEED    3    pixels moved down per frame
//  LOWER_BORDER  479  bomb retires when its top y exceeds this
//  CANNON_Y      470  top row of cannon
//  CANNON_W      52   cannon width, pixels
//  CANNON_H      32   cannon height, pixels
//  FIRE_INTERVAL 40   minimum frames between accepted launches
// PORTS
//  clock        in   1   system/pixel clock
//  reset_n      in   1   asynchronous active-low reset
//  vpos         in   10  current scan row
//  hpos         in   10  current scan column
//  vsync        in   1   vertical sync, synchronous to clock
//  enable       in   1   1 = play; 0 = freeze (no move, no launch, bombs hold)
//  clear        in   1   synchronous: retire all bombs, zero cooldown
//  fire_req     in   1   formation requests a launch
//  fire_x       in   10  launch column (bomb left edge)
//  fire_y       in   10  launch row (bomb top edge)
//  fire_ack     out  1   launch accepted this cycle
//  cannon_x     in   10  cannon left edge
//  cannon_hit   out  1   one-cycle pulse: at least one bomb struck the cannon
//  bombs_active out  4   count of active slots
//  bomb_gfx     out  1   current pixel lies inside an active bomb
// BEHAVIOUR
//  Reset (asynchronous, reset_n=0) forces the following state:
//   - all slots inactive; cooldown=0; vsync_q=1
//   - fire_ack=0, cannon_hit=0, bombs_active=0, bomb_gfx=0
//  Frame tick: tick = vsync & ~vsync_q. It is combinational; vsync_q is registered.
//   vsync_q reset to 1, so no spurious tick when vsync is high out of reset.
//  Bomb box: width 1*SCALING, height 3*SCALING. Each slot holds active, x, y (10b each).
//  Launch handshake: fire_ack = fire_req & enable & ~clear & ~tick & cooldown==0
//   & any slot free. It is combinational, with no latency. On the clock edge with fire_ack=1:
//   - the lowest-index free slot loads x=fire_x, y=fire_y, active=1
//   - cooldown loads FIRE_INTERVAL
//  If fire_ack is not given, the request is not stored. The formation holds or drops it.
//  Movement, on a tick edge with enable=1, for each active slot:
//   - new_y = y + BOMB_SPEED, computed at 11 bits (no wrap)
//   - hit = box at (x,new_y) overlaps cannon box
//     [cannon_x, cannon_x+CANNON_W) x [CANNON_Y, CANNON_Y+CANNON_H), 11-bit compares
//   - hit or new_y > LOWER_BORDER: slot retires (active=0); else y <= new_y
//   - hit and border exit together: treated as hit
//  cannon_hit is registered. It is 1 for exactly the cycle after a tick in which any
//   slot hit. Several simultaneous hits still give one pulse, and all hitting slots retire.
//  Cooldown decrements by 1 per tick while enable=1 and it is nonzero. It saturates at 0.
//  enable=0: ticks are ignored, fire_ack=0, and cooldown holds. bomb_gfx still draws.
//  clear=1: next edge retires all slots and zeroes cooldown. clear wins over tick and launch.
//  bombs_active: combinational popcount of the active bits.
//  bomb_gfx: combinational OR over slots of active & hpos in [x, x+SCALING)
//   & vpos in [y, y+3*SCALING).
//  Reset asserted mid-frame clears everything immediately. On release, operation resumes
//   at the next tick.
// TESTING
//  1. Reset, enable=1, fire_req=1 with fire_x=100, fire_y=200:
//     fire_ack=1 same cycle; slot0 y=200; bombs_active=1.
//  2. After launch, 5 ticks: y=215. Pixel (100,215) gives bomb_gfx=1.
//     Pixel (104,215) gives 0.
//  3. Bomb at y=477, tick: new_y=480>479, so it retires, bombs_active drops by 1,
//     and cannon_hit stays 0.
//  4. cannon_x=90, bomb x=100 y=460, tick: new_y=463, box reaches 474 >= 470,
//     so cannon_hit pulses 1 cycle and the slot retires.
//  5. Launch, then fire_req held high: ack only after 40 ticks. With 3 slots active,
//     the 4th request gets no ack. A request coinciding with a tick gets no ack.
//  6. Two bombs hit in the same tick: one cannon_hit pulse, both retire.
//     clear during a tick: all retire, no move.

Source files
------------

// File: rtl/alien_bomb_ctrl_if.sv
// Launch handshake between the alien formation and the bomb engine.
//   fire_req : formation requests a bomb launch
//   fire_x   : launch column (bomb left edge)
//   fire_y   : launch row (bomb top edge)
//   fire_ack : launch accepted this cycle (combinational, no latency)
// master = formation side, slave = bomb engine side.
interface alien_bomb_ctrl_if;
  logic       fire_req;
  logic [9:0] fire_x;
  logic [9:0] fire_y;
  logic       fire_ack;

  modport master (output fire_req, output fire_x, output fire_y, input fire_ack);
  modport slave  (input fire_req, input fire_x, input fire_y, output fire_ack);
endinterface

// File: rtl/alien_bomb_ctrl.sv
// Alien bomb engine: owns NUM_BOMBS falling bomb slots, launches them on
// formation request, moves them once per frame, detects cannon hits and
// draws the bomb pixel.
//   clock, reset_n : clock and asynchronous active-low reset
//   vpos, hpos     : current scan row / column
//   vsync          : vertical sync; its rising edge is the frame tick
//   enable         : 1 = play, 0 = freeze (bombs hold, no launch)
//   clear          : retire all bombs and zero the launch cooldown
//   fire           : launch handshake (slave side)
//   cannon_x       : cannon left edge
//   cannon_hit     : one-cycle pulse after a tick in which any bomb hit
//   bombs_active   : number of active slots
//   bomb_gfx       : current pixel lies inside an active bomb
module alien_bomb_ctrl #(
  parameter int unsigned NUM_BOMBS     = 3,
  parameter int unsigned SCALING       = 4,
  parameter int unsigned BOMB_SPEED    = 3,
  parameter int unsigned LOWER_BORDER  = 479,
  parameter int unsigned CANNON_Y      = 470,
  parameter int unsigned CANNON_W      = 52,
  parameter int unsigned CANNON_H      = 32,
  parameter int unsigned FIRE_INTERVAL = 40
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [9:0]           vpos,
  input  logic [9:0]           hpos,
  input  logic                 vsync,
  input  logic                 enable,
  input  logic                 clear,
  alien_bomb_ctrl_if.slave     fire,
  input  logic [9:0]           cannon_x,
  output logic                 cannon_hit,
  output logic [3:0]           bombs_active,
  output logic                 bomb_gfx
);

  localparam int unsigned IdxW = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
  localparam int unsigned CdW  = (FIRE_INTERVAL > 0) ? $clog2(FIRE_INTERVAL + 1) : 1;

  logic                 vsync_q;
  logic [NUM_BOMBS-1:0] active_q;
  logic [9:0]           x_q [NUM_BOMBS];
  logic [9:0]           y_q [NUM_BOMBS];
  logic [CdW-1:0]       cooldown_q;
  logic                 cannon_hit_q;

  logic                 tick;
  logic                 move;
  logic                 any_free;
  logic [IdxW-1:0]      free_idx;
  logic [10:0]          new_y [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] hit;
  logic [NUM_BOMBS-1:0] exit_b;
  logic [NUM_BOMBS-1:0] gfx;

  // vsync_q resets to 1 so a vsync already high at reset release is not a tick.
  assign tick = vsync & ~vsync_q;
  assign move = tick & enable;

  // Scan downwards so the lowest-index free slot wins.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  assign fire.fire_ack = fire.fire_req & enable & ~clear & ~tick &
                         (cooldown_q == '0) & any_free;

  // Next position and cannon overlap, all at 11 bits so nothing wraps.
  always_comb begin
    for (int i = 0; i < NUM_BOMBS; i++) begin
      new_y[i]  = {1'b0, y_q[i]} + 11'(BOMB_SPEED);
      hit[i]    = active_q[i] &
                  ({1'b0, x_q[i]} < ({1'b0, cannon_x} + 11'(CANNON_W))) &
                  (({1'b0, x_q[i]} + 11'(SCALING)) > {1'b0, cannon_x}) &
                  (new_y[i] < 11'(CANNON_Y + CANNON_H)) &
                  ((new_y[i] + 11'(3 * SCALING)) > 11'(CANNON_Y));
      exit_b[i] = new_y[i] > 11'(LOWER_BORDER);
      gfx[i]    = active_q[i] &
                  ({1'b0, hpos} >= {1'b0, x_q[i]}) &
                  ({1'b0, hpos} < ({1'b0, x_q[i]} + 11'(SCALING))) &
                  ({1'b0, vpos} >= {1'b0, y_q[i]}) &
                  ({1'b0, vpos} < ({1'b0, y_q[i]} + 11'(3 * SCALING)));
    end
  end

  always_comb begin
    bombs_active = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      bombs_active = bombs_active + 4'(active_q[i]);
    end
  end

  assign bomb_gfx   = |gfx;
  assign cannon_hit = cannon_hit_q;

  // Launches never coincide with movement because fire_ack excludes tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q      <= 1'b1;
      active_q     <= '0;
      cooldown_q   <= '0;
      cannon_hit_q <= 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      vsync_q      <= vsync;
      cannon_hit_q <= 1'b0;
      if (clear) begin
        active_q   <= '0;
        cooldown_q <= '0;
      end else if (move) begin
        cannon_hit_q <= |hit;
        for (int i = 0; i < NUM_BOMBS; i++) begin
          if (active_q[i]) begin
            if (hit[i] || exit_b[i]) begin
              active_q[i] <= 1'b0;
            end else begin
              y_q[i] <= new_y[i][9:0];
            end
          end
        end
        if (cooldown_q != '0) begin
          cooldown_q <= cooldown_q - CdW'(1);
        end
      end else if (fire.fire_ack) begin
        active_q[free_idx] <= 1'b1;
        x_q[free_idx]      <= fire.fire_x;
        y_q[free_idx]      <= fire.fire_y;
        cooldown_q         <= CdW'(FIRE_INTERVAL);
      end
    end
  end

endmodule

// File: tb/tb_alien_bomb_ctrl.sv
module tb_alien_bomb_ctrl;

  logic       clock;
  logic       reset_n;
  logic [9:0] vpos;
  logic [9:0] hpos;
  logic       vsync;
  logic       enable;
  logic       clear;
  logic [9:0] cannon_x;
  logic       cannon_hit;
  logic [3:0] bombs_active;
  logic       bomb_gfx;

  int vectors;
  int miscompares;

  alien_bomb_ctrl_if bus ();

  alien_bomb_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .vpos         (vpos),
    .hpos         (hpos),
    .vsync        (vsync),
    .enable       (enable),
    .clear        (clear),
    .fire         (bus),
    .cannon_x     (cannon_x),
    .cannon_hit   (cannon_hit),
    .bombs_active (bombs_active),
    .bomb_gfx     (bomb_gfx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One frame: vsync rises (tick on the first edge), then falls.
  task automatic frame();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  // Launch request for one cycle; acceptance is checked by the caller's scenario.
  task automatic launch(input logic [9:0] x, input logic [9:0] y);
    bus.fire_req = 1'b1;
    bus.fire_x   = x;
    bus.fire_y   = y;
    #1;
    vectors++;
    if (bus.fire_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL launch_ack x=%0d y=%0d: got %b want 1", x, y, bus.fire_ack);
    end
    cyc();
    bus.fire_req = 1'b0;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic exp, input string nm);
    hpos = h;
    vpos = v;
    #1;
    vectors++;
    if (bomb_gfx !== exp) begin
      miscompares++;
      $display("FAIL %s (%0d,%0d): got %b want %b", nm, h, v, bomb_gfx, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vsync = 1'b1; enable = 1'b1; clear = 1'b0; cannon_x = 10'd600;
    hpos = 10'd0; vpos = 10'd0;
    bus.fire_req = 1'b0; bus.fire_x = 10'd0; bus.fire_y = 10'd0;
    #2;
    vectors++;
    if (bombs_active !== 4'd0 || cannon_hit !== 1'b0 || bomb_gfx !== 1'b0 || bus.fire_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got act=%0d hit=%b gfx=%b ack=%b want 0 0 0 0",
               bombs_active, cannon_hit, bomb_gfx, bus.fire_ack);
    end
    cyc(); cyc();
    reset_n = 1'b1;
    // vsync held high through release must not tick, so the launch is accepted.
    launch(10'd100, 10'd200);
    vectors++;
    if (bombs_active !== 4'd1) begin
      miscompares++;
      $display("FAIL reset_launch_active: got %0d want 1", bombs_active);
    end
    pix(10'd100, 10'd200, 1'b1, "launch_gfx");
    vsync = 1'b0;
    cyc();
  endtask

  task automatic test_move();
    frames(5);
    pix(10'd100, 10'd215, 1'b1, "move_gfx_top");
    pix(10'd104, 10'd215, 1'b0, "move_gfx_right");
    pix(10'd99,  10'd215, 1'b0, "move_gfx_left");
    pix(10'd103, 10'd226, 1'b1, "move_gfx_bottom");
    pix(10'd100, 10'd227, 1'b0, "move_gfx_below");
    pix(10'd100, 10'd214, 1'b0, "move_gfx_above");
  endtask

  // Cooldown is 35 after five ticks; it must hold across the freeze.
  task automatic test_freeze();
    enable = 1'b0;
    frames(3);
    pix(10'd100, 10'd215, 1'b1, "freeze_gfx");
    enable = 1'b1;
    frames(34);
    bus.fire_req = 1'b1;
    #1;
    vectors++;
    if (bus.fire_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL freeze_cooldown_hold: got ack=%b want 0", bus.fire_ack);
    end
    bus.fire_req = 1'b0;
    frame();
    pix(10'd100, 10'd320, 1'b1, "freeze_resume_gfx");
    bus.fire_req = 1'b1;
    #1;
    vectors++;
    if (bus.fire_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL freeze_cooldown_done: got ack=%b want 1", bus.fire_ack);
    end
    bus.fire_req = 1'b0;
  endtask

  task automatic test_border();
    do_clear();
    cannon_x = 10'd600;
    launch(10'd100, 10'd476);
    frame();
    vectors++;
    if (bombs_active !== 4'd1) begin
      miscompares++;
      $display("FAIL border_479_stays: got %0d want 1", bombs_active);
    end
    pix(10'd100, 10'd479, 1'b1, "border_gfx_479");
    do_clear();
    launch(10'd100, 10'd477);
    vsync = 1'b1;
    cyc();
    vectors++;
    if (bombs_active !== 4'd0 || cannon_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL border_retire: got act=%0d hit=%b want 0 0", bombs_active, cannon_hit);
    end
    vsync = 1'b0;
    cyc();
  endtask

  task automatic test_hit();
    do_clear();
    cannon_x = 10'd90;
    launch(10'd100, 10'd460);
    vsync = 1'b1;
    cyc();
    vectors++;
    if (cannon_hit !== 1'b1 || bombs_active !== 4'd0) begin
      miscompares++;
      $display("FAIL hit_pulse: got hit=%b act=%0d want 1 0", cannon_hit, bombs_active);
    end
    vsync = 1'b0;
    cyc();
    vectors++;
    if (cannon_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_one_cycle: got %b want 0", cannon_hit);
    end
    // Right edge 104 touching cannon left edge 104 is not an overlap.
    do_clear();
    cannon_x = 10'd104;
    launch(10'd100, 10'd460);
    vsync = 1'b1;
    cyc();
    vectors++;
    if (cannon_hit !== 1'b0 || bombs_active !== 4'd1) begin
      miscompares++;
      $display("FAIL hit_edge_miss: got hit=%b act=%0d want 0 1", cannon_hit, bombs_active);
    end
    vsync = 1'b0;
    cyc();
    cannon_x = 10'd101;
    vsync = 1'b1;
    cyc();
    vectors++;
    if (cannon_hit !== 1'b1 || bombs_active !== 4'd0) begin
      miscompares++;
      $display("FAIL hit_edge_hit: got hit=%b act=%0d want 1 0", cannon_hit, bombs_active);
    end
    vsync = 1'b0;
    cyc();
  endtask

  task automatic test_cooldown();
    do_clear();
    cannon_x = 10'd600;
    launch(10'd20, 10'd0);
    frames(39);
    bus.fire_req = 1'b1;
    #1;
    vectors++;
    if (bus.fire_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL cooldown_39: got %b want 0", bus.fire_ack);
    end
    bus.fire_req = 1'b0;
    frame();
    vsync = 1'b1;
    bus.fire_req = 1'b1;
    #1;
    vectors++;
    if (bus.fire_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL cooldown_tick_block: got %b want 0", bus.fire_ack);
    end
    cyc();
    vsync = 1'b0;
    bus.fire_req = 1'b0;
    launch(10'd40, 10'd0);
    vectors++;
    if (bombs_active !== 4'd2) begin
      miscompares++;
      $display("FAIL cooldown_two: got %0d want 2", bombs_active);
    end
    frames(40);
    launch(10'd60, 10'd0);
    frames(40);
    bus.fire_req = 1'b1;
    #1;
    vectors++;
    if (bus.fire_ack !== 1'b0 || bombs_active !== 4'd3) begin
      miscompares++;
      $display("FAIL slots_full: got ack=%b act=%0d want 0 3", bus.fire_ack, bombs_active);
    end
    bus.fire_req = 1'b0;
    // First bomb: 121 ticks from y=0.
    pix(10'd20, 10'd363, 1'b1, "slots_gfx_slot0");
  endtask

  task automatic test_multi_hit();
    do_clear();
    cannon_x = 10'd90;
    launch(10'd100, 10'd0);
    frames(40);
    launch(10'd110, 10'd120);
    frames(112);
    vectors++;
    if (bombs_active !== 4'd2) begin
      miscompares++;
      $display("FAIL multi_pre: got %0d want 2", bombs_active);
    end
    pix(10'd110, 10'd456, 1'b1, "multi_pre_gfx");
    vsync = 1'b1;
    cyc();
    vectors++;
    if (cannon_hit !== 1'b1 || bombs_active !== 4'd0) begin
      miscompares++;
      $display("FAIL multi_hit: got hit=%b act=%0d want 1 0", cannon_hit, bombs_active);
    end
    vsync = 1'b0;
    cyc();
    vectors++;
    if (cannon_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_single_pulse: got %b want 0", cannon_hit);
    end
  endtask

  task automatic test_clear_tick();
    do_clear();
    cannon_x = 10'd600;
    launch(10'd300, 10'd100);
    vsync = 1'b1;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    vsync = 1'b0;
    vectors++;
    if (bombs_active !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_tick_retire: got %0d want 0", bombs_active);
    end
    pix(10'd300, 10'd103, 1'b0, "clear_tick_gfx");
    launch(10'd300, 10'd100);
    pix(10'd300, 10'd100, 1'b1, "clear_relaunch_gfx");
  endtask

  task automatic test_reset_midframe();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bombs_active !== 4'd0 || bomb_gfx !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset: got act=%0d gfx=%b want 0 0", bombs_active, bomb_gfx);
    end
    cyc();
    reset_n = 1'b1;
    launch(10'd200, 10'd50);
    frame();
    pix(10'd200, 10'd53, 1'b1, "midframe_resume_gfx");
    pix(10'd200, 10'd52, 1'b0, "midframe_resume_above");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_move();
    test_freeze();
    test_border();
    test_hit();
    test_cooldown();
    test_multi_hit();
    test_clear_tick();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
